// File: rtl/vid_bus_master_arb.sv
// vid_bus_master_arb: shares the graphics master port among NREQ fetch engines,
// running request/ack, address phase, write streaming and read-return collection.
module vid_bus_master_arb #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NREQ-1:0]     rq_valid,
    input  logic [NREQ-1:0]     rq_urgent,
    input  logic [3*NREQ-1:0]   rq_cmd,
    input  logic [32*NREQ-1:0]  rq_addr,
    input  logic [2*NREQ-1:0]   rq_len,
    input  logic [4*NREQ-1:0]   rq_tar,
    input  logic [32*NREQ-1:0]  rq_wdata,
    output logic [NREQ-1:0]     rq_grant,
    output logic [NREQ-1:0]     rq_wready,
    output logic [NREQ-1:0]     rq_rvalid,
    output logic [31:0]         rd_data,
    output logic [NREQ-1:0]     rq_done,
    output logic [2:0]          cmdout,
    output logic [31:0]         addrdataout,
    output logic [1:0]          lenout,
    output logic [1:0]          reqout,
    output logic [3:0]          reqtar,
    input  logic                ackin,
    input  logic [2:0]          cmdin,
    input  logic [31:0]         addrdatain,
    input  logic                selin,
    output logic                interrupt
);
    localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [2:0] RD = 3'b001, WR = 3'b010, WD = 3'b100, RB = 3'b011;
    typedef enum logic [2:0] {IDLE, REQ, ADDR, WBEAT, RWAIT} state_t;
    state_t state;
    logic [IW-1:0] ptr, win, pick, j;
    logic [2:0] cmd;
    logic [31:0] addr;
    logic [1:0] len, beat;
    logic [CW-1:0] cnt;
    logic [NREQ-1:0] sel;
    logic found, rbeat, expired;
    assign sel = NREQ'(1) << win;
    assign rbeat = selin && cmdin == RB;
    assign expired = cnt == CW'(TIMEOUT - 1);
    // urgent requesters take lowest index; otherwise first valid after the last grant
    always_comb begin
        pick = '0;
        j = '0;
        found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--)
            if (rq_valid[i] && rq_urgent[i]) begin
                pick = IW'(i);
                found = 1'b1;
            end
        if (!found)
            for (int i = NREQ; i >= 1; i--) begin
                j = IW'((int'(ptr) + i) % NREQ);
                if (rq_valid[j]) pick = j;
            end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ptr <= IW'(NREQ - 1);
            win <= '0;
            cmd <= '0;
            addr <= '0;
            len <= '0;
            beat <= '0;
            cnt <= '0;
            rq_grant <= '0;
            rq_wready <= '0;
            rq_rvalid <= '0;
            rd_data <= '0;
            rq_done <= '0;
            cmdout <= '0;
            addrdataout <= '0;
            lenout <= '0;
            reqout <= '0;
            reqtar <= '0;
            interrupt <= 1'b0;
        end else begin
            rq_grant <= '0;
            rq_wready <= '0;
            rq_rvalid <= '0;
            rq_done <= '0;
            cmdout <= '0;
            addrdataout <= '0;
            lenout <= '0;
            interrupt <= 1'b0;
            case (state)
                IDLE: if (enable && |rq_valid) begin
                    win <= pick;
                    cmd <= (rq_cmd[3*pick +: 3] == WR) ? WR : RD;
                    addr <= rq_addr[32*pick +: 32];
                    len <= rq_len[2*pick +: 2];
                    reqout <= rq_urgent[pick] ? 2'b11 : 2'b01;
                    reqtar <= rq_tar[4*pick +: 4];
                    cnt <= '0;
                    state <= REQ;
                end
                REQ: if (ackin) begin
                    reqout <= '0;
                    reqtar <= '0;
                    cmdout <= cmd;
                    addrdataout <= addr;
                    lenout <= len;
                    rq_grant <= sel;
                    ptr <= win;
                    state <= ADDR;
                end else if (expired) begin
                    reqout <= '0;
                    reqtar <= '0;
                    interrupt <= 1'b1;
                    rq_done <= sel;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                ADDR: begin
                    beat <= '0;
                    cnt <= '0;
                    if (cmd == WR) begin
                        cmdout <= WD;
                        addrdataout <= rq_wdata[32*win +: 32];
                        rq_wready <= sel;
                        rq_done <= (len == 2'd0) ? sel : '0;
                        state <= WBEAT;
                    end else begin
                        state <= RWAIT;
                    end
                end
                WBEAT: if (beat == len) begin
                    state <= IDLE;
                end else begin
                    beat <= beat + 2'd1;
                    cmdout <= WD;
                    addrdataout <= rq_wdata[32*win +: 32];
                    rq_wready <= sel;
                    rq_done <= (beat + 2'd1 == len) ? sel : '0;
                end
                RWAIT: if (rbeat) begin
                    cnt <= '0;
                    rd_data <= addrdatain;
                    rq_rvalid <= sel;
                    if (beat == len) begin
                        rq_done <= sel;
                        state <= IDLE;
                    end else begin
                        beat <= beat + 2'd1;
                    end
                end else if (expired) begin
                    interrupt <= 1'b1;
                    rq_done <= sel;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vid_bus_master_arb.sv
// tb_vid_bus_master_arb: randomized bench checking vid_bus_master_arb against a transaction-level model.
module tb_vid_bus_master_arb;
    localparam int NREQ = 2;
    localparam int TO = 8;
    logic clk = 1'b0;
    logic reset, enable, ackin, selin;
    logic [NREQ-1:0] rq_valid, rq_urgent, rq_grant, rq_wready, rq_rvalid, rq_done;
    logic [3*NREQ-1:0] rq_cmd;
    logic [32*NREQ-1:0] rq_addr, rq_wdata;
    logic [2*NREQ-1:0] rq_len;
    logic [4*NREQ-1:0] rq_tar;
    logic [31:0] rd_data, addrdataout, addrdatain;
    logic [2:0] cmdout, cmdin;
    logic [1:0] lenout, reqout;
    logic [3:0] reqtar;
    logic interrupt;
    int checks = 0;
    int errors = 0;
    int last_grant = NREQ - 1;
    logic [2:0] m_cmd [NREQ];
    logic [31:0] m_addr [NREQ];
    logic [1:0] m_len [NREQ];
    logic [3:0] m_tar [NREQ];
    logic [31:0] wq [NREQ][4];
    int wi [NREQ];

    always #5 clk = ~clk;

    vid_bus_master_arb #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .rq_valid(rq_valid), .rq_urgent(rq_urgent), .rq_cmd(rq_cmd), .rq_addr(rq_addr),
        .rq_len(rq_len), .rq_tar(rq_tar), .rq_wdata(rq_wdata),
        .rq_grant(rq_grant), .rq_wready(rq_wready), .rq_rvalid(rq_rvalid), .rd_data(rd_data),
        .rq_done(rq_done), .cmdout(cmdout), .addrdataout(addrdataout), .lenout(lenout),
        .reqout(reqout), .reqtar(reqtar), .ackin(ackin), .cmdin(cmdin),
        .addrdatain(addrdatain), .selin(selin), .interrupt(interrupt)
    );

    task automatic drive_w(input int i);
        rq_wdata[32*i +: 32] = wq[i][wi[i] > 3 ? 3 : wi[i]];
    endtask

    task automatic set_req(input int i, input logic v, input logic u, input logic [2:0] c,
                           input logic [31:0] a, input logic [1:0] l, input logic [3:0] t);
        m_cmd[i] = c;
        m_addr[i] = a;
        m_len[i] = l;
        m_tar[i] = t;
        rq_valid[i] = v;
        rq_urgent[i] = u;
        rq_cmd[3*i +: 3] = c;
        rq_addr[32*i +: 32] = a;
        rq_len[2*i +: 2] = l;
        rq_tar[4*i +: 4] = t;
        for (int b = 0; b < 4; b++) wq[i][b] = $urandom;
        wi[i] = 0;
        drive_w(i);
    endtask

    task automatic rand_req(input int i, input logic v, input logic u);
        logic [2:0] c;
        c = ($urandom_range(0, 4) == 0) ? 3'($urandom) : (($urandom_range(0, 1) == 1) ? 3'b010 : 3'b001);
        set_req(i, v, u, c, $urandom, 2'($urandom), 4'($urandom));
    endtask

    // Reference arbitration: urgent lowest index, else first valid after the last grant.
    function automatic int model_winner();
        for (int i = 0; i < NREQ; i++)
            if (rq_valid[i] && rq_urgent[i]) return i;
        for (int k = 1; k <= NREQ; k++)
            if (rq_valid[(last_grant + k) % NREQ]) return (last_grant + k) % NREQ;
        return -1;
    endfunction

    // Plays the bus slave for one transaction, starting at a negedge in IDLE with requests driven.
    task automatic run_txn(input int ack_dly, input int gap_max, input bit fixed, output int got);
        int w, n, beat, gap;
        logic [NREQ-1:0] oh;
        logic [2:0] ecmd;
        logic [1:0] ereq;
        logic pending;
        logic [31:0] pdata;
        got = -1;
        w = model_winner();
        checks++;
        if (w < 0) begin
            errors++;
            $display("FAIL txn_setup: no valid requester, required at least one");
            return;
        end
        oh = '0;
        oh[w] = 1'b1;
        ecmd = (m_cmd[w] == 3'b010) ? 3'b010 : 3'b001;
        ereq = rq_urgent[w] ? 2'b11 : 2'b01;
        n = int'(m_len[w]) + 1;
        pdata = '0;
        for (int c = 0; c <= ack_dly; c++) begin
            @(negedge clk);
            checks++;
            if (reqout !== ereq || reqtar !== m_tar[w] || cmdout !== 3'b000 || rq_grant !== '0 || interrupt !== 1'b0) begin
                errors++;
                $display("FAIL req_phase: c=%0d reqout=%b reqtar=%h cmdout=%b grant=%b irq=%b, required reqout=%b reqtar=%h idle",
                         c, reqout, reqtar, cmdout, rq_grant, interrupt, ereq, m_tar[w]);
            end
            ackin = (c == ack_dly);
            selin = 1'b1;
            cmdin = 3'b011;
            addrdatain = $urandom;
        end
        @(negedge clk);
        ackin = 1'b0;
        for (int i = 0; i < NREQ; i++) if (rq_grant[i]) got = i;
        checks++;
        if (rq_grant !== oh || cmdout !== ecmd || addrdataout !== m_addr[w] || lenout !== m_len[w] || reqout !== 2'b00 || interrupt !== 1'b0) begin
            errors++;
            $display("FAIL addr_phase: grant=%b cmd=%b addr=%h len=%0d reqout=%b irq=%b, required grant=%b cmd=%b addr=%h len=%0d",
                     rq_grant, cmdout, addrdataout, lenout, reqout, interrupt, oh, ecmd, m_addr[w], m_len[w]);
        end
        last_grant = w;
        if (ecmd == 3'b010) begin
            selin = 1'b0;
            for (int b = 0; b < n; b++) begin
                @(negedge clk);
                checks++;
                if (cmdout !== 3'b100 || addrdataout !== wq[w][b] || rq_wready !== oh || rq_done !== ((b == n - 1) ? oh : '0) || rq_rvalid !== '0) begin
                    errors++;
                    $display("FAIL write_beat: b=%0d cmd=%b data=%h wready=%b done=%b, required cmd=100 data=%h wready=%b",
                             b, cmdout, addrdataout, rq_wready, rq_done, wq[w][b], oh);
                end
                wi[w]++;
                drive_w(w);
                if (b == n - 1) rq_valid[w] = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (cmdout !== 3'b000 || rq_wready !== '0 || rq_done !== '0 || reqout !== 2'b00) begin
                errors++;
                $display("FAIL write_end: cmd=%b wready=%b done=%b reqout=%b, required all zero", cmdout, rq_wready, rq_done, reqout);
            end
        end else begin
            selin = 1'b1;
            cmdin = 3'b011;
            addrdatain = 32'hBAD0_0000;
            pending = 1'b0;
            beat = 0;
            gap = fixed ? 0 : $urandom_range(0, gap_max);
            for (int c = 0; c < 64; c++) begin
                @(negedge clk);
                checks++;
                if (rq_rvalid !== (pending ? oh : '0) || (pending && rd_data !== pdata) ||
                    rq_done !== ((pending && beat == n) ? oh : '0) || rq_wready !== '0 || interrupt !== 1'b0) begin
                    errors++;
                    $display("FAIL read_beat: beat=%0d rvalid=%b data=%h done=%b irq=%b, required rvalid=%b data=%h last=%0d",
                             beat, rq_rvalid, rd_data, rq_done, interrupt, pending ? oh : '0, pdata, beat == n);
                end
                if (pending && beat == n) break;
                if (gap > 0) begin
                    selin = 1'($urandom_range(0, 1));
                    cmdin = 3'b001;
                    gap--;
                    pending = 1'b0;
                end else begin
                    selin = 1'b1;
                    cmdin = 3'b011;
                    pdata = fixed ? 32'hA0 + 32'(beat) : $urandom;
                    addrdatain = pdata;
                    beat++;
                    pending = 1'b1;
                    gap = fixed ? ((beat == 2) ? 1 : 0) : $urandom_range(0, gap_max);
                end
            end
            rq_valid[w] = 1'b0;
            selin = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        ackin = 1'b0;
        selin = 1'b0;
        cmdin = '0;
        addrdatain = '0;
        rq_valid = '0;
        rq_urgent = '0;
        rq_cmd = '0;
        rq_addr = '0;
        rq_len = '0;
        rq_tar = '0;
        rq_wdata = '0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 3'b000, '0, '0, '0);
        repeat (3) @(negedge clk);
        checks++;
        if ({rq_grant, rq_wready, rq_rvalid, rd_data, rq_done, cmdout, addrdataout, lenout, reqout, reqtar, interrupt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: reqout=%b cmd=%b data=%h irq=%b, required all zero", reqout, cmdout, addrdataout, interrupt);
        end
        reset = 1'b0;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if (reqout !== 2'b00 || rq_done !== '0) begin
            errors++;
            $display("FAIL idle_no_request: reqout=%b done=%b, required 00 and 0", reqout, rq_done);
        end
    endtask

    task automatic test_single_read();
        int got;
        set_req(0, 1'b1, 1'b0, 3'b001, 32'h0000_1000, 2'd3, 4'd5);
        run_txn(2, 0, 1'b1, got);
        checks++;
        if (got != 0) begin
            errors++;
            $display("FAIL single_read_grant: got=%0d required 0", got);
        end
    endtask

    task automatic test_write_burst();
        int got;
        set_req(1, 1'b1, 1'b0, 3'b010, 32'h0000_2000, 2'd1, 4'd9);
        wq[1][0] = 32'h0000_DEAD;
        wq[1][1] = 32'h0000_BEEF;
        drive_w(1);
        run_txn(0, 0, 1'b0, got);
        checks++;
        if (got != 1) begin
            errors++;
            $display("FAIL write_burst_grant: got=%0d required 1", got);
        end
    endtask

    task automatic test_round_robin();
        int got;
        rand_req(0, 1'b1, 1'b0);
        rand_req(1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_txn($urandom_range(0, 3), 2, 1'b0, got);
            checks++;
            if (got != k % 2) begin
                errors++;
                $display("FAIL round_robin: txn %0d granted %0d required %0d", k, got, k % 2);
            end
            if (got >= 0) rand_req(got, 1'b1, 1'b0);
        end
    endtask

    task automatic test_urgent();
        int got;
        rand_req(0, 1'b1, 1'b0);
        rand_req(1, 1'b1, 1'b1);
        run_txn(1, 2, 1'b0, got);
        checks++;
        if (got != 1) begin
            errors++;
            $display("FAIL urgent_preempt: granted %0d required 1", got);
        end
    endtask

    task automatic test_timeout();
        int n;
        rand_req(1, 1'b0, 1'b0);
        set_req(0, 1'b1, 1'b0, 3'b001, 32'h0000_3000, 2'd0, 4'd2);
        ackin = 1'b0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (reqout === 2'b00) break;
            n++;
        end
        rq_valid[0] = 1'b0;
        checks++;
        if (n != TO || interrupt !== 1'b1 || rq_done !== 2'b01 || rq_grant !== '0) begin
            errors++;
            $display("FAIL req_timeout: req cycles=%0d irq=%b done=%b grant=%b, required %0d cycles irq=1 done=01",
                     n, interrupt, rq_done, rq_grant, TO);
        end
        @(negedge clk);
        checks++;
        if (interrupt !== 1'b0 || rq_done !== '0 || reqout !== 2'b00) begin
            errors++;
            $display("FAIL timeout_pulse: irq=%b done=%b reqout=%b, required one-cycle pulse then idle", interrupt, rq_done, reqout);
        end
        set_req(1, 1'b1, 1'b0, 3'b001, 32'h0000_4000, 2'd2, 4'd1);
        @(negedge clk);
        ackin = 1'b1;
        @(negedge clk);
        ackin = 1'b0;
        last_grant = 1;
        @(negedge clk);
        selin = 1'b1;
        cmdin = 3'b011;
        addrdatain = 32'h5555_AAAA;
        @(negedge clk);
        selin = 1'b0;
        checks++;
        if (rq_rvalid !== 2'b10 || rd_data !== 32'h5555_AAAA || rq_done !== '0) begin
            errors++;
            $display("FAIL read_first_beat: rvalid=%b data=%h done=%b, required 10 5555aaaa 00", rq_rvalid, rd_data, rq_done);
        end
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n++;
            if (interrupt === 1'b1) break;
        end
        rq_valid[1] = 1'b0;
        checks++;
        if (n != TO || rq_done !== 2'b10 || rq_rvalid !== '0) begin
            errors++;
            $display("FAIL read_timeout: cycles=%0d done=%b rvalid=%b, required %0d cycles done=10", n, rq_done, rq_rvalid, TO);
        end
    endtask

    task automatic test_ack_at_timeout();
        int got;
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 3'b001, 32'h0000_6000, 2'd0, 4'd3);
        run_txn(TO - 1, 1, 1'b0, got);
        checks++;
        if (got != 0) begin
            errors++;
            $display("FAIL ack_at_timeout: granted %0d required 0", got);
        end
    endtask

    task automatic test_random();
        int got;
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < NREQ; i++) rand_req(i, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
            if (rq_valid == '0) rq_valid[$urandom_range(0, NREQ - 1)] = 1'b1;
            run_txn($urandom_range(0, TO - 1), 3, 1'b0, got);
        end
    endtask

    task automatic test_reset_mid_read();
        int got;
        rand_req(1, 1'b0, 1'b0);
        set_req(0, 1'b1, 1'b0, 3'b001, 32'h0000_7000, 2'd3, 4'd4);
        @(negedge clk);
        ackin = 1'b1;
        @(negedge clk);
        ackin = 1'b0;
        @(negedge clk);
        selin = 1'b1;
        cmdin = 3'b011;
        addrdatain = $urandom;
        @(negedge clk);
        selin = 1'b0;
        reset = 1'b1;
        enable = 1'b0;
        rand_req(1, 1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if ({rq_grant, rq_wready, rq_rvalid, rd_data, rq_done, cmdout, addrdataout, lenout, reqout, reqtar, interrupt} !== '0) begin
            errors++;
            $display("FAIL reset_mid_read: rvalid=%b data=%h done=%b irq=%b, required all zero", rq_rvalid, rd_data, rq_done, interrupt);
        end
        reset = 1'b0;
        last_grant = NREQ - 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if ({rq_grant, rq_wready, rq_rvalid, rd_data, rq_done, cmdout, addrdataout, lenout, reqout, reqtar, interrupt} !== '0) begin
                errors++;
                $display("FAIL enable_low: cycle %0d reqout=%b done=%b irq=%b, required all zero", c, reqout, rq_done, interrupt);
            end
        end
        enable = 1'b1;
        run_txn(1, 2, 1'b0, got);
        checks++;
        if (got != 0) begin
            errors++;
            $display("FAIL pointer_after_reset: granted %0d required 0", got);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_read();
        test_write_burst();
        test_round_robin();
        test_urgent();
        test_timeout();
        test_ack_at_timeout();
        test_random();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
